// File: rtl/inst_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack, redirect from execute, decode handshake.
// No logic; the fetch unit connects through the master modport, its environment through slave.
// Ports: IMemReq/IMemAddr/IMemAck/IMemRdata, Redirect/RedirectPC, InstValid/InstReady/InstCode/InstPC.
interface inst_fetch_unit_if;
   logic        IMemReq;
   logic [31:0] IMemAddr;
   logic        IMemAck;
   logic [31:0] IMemRdata;
   logic        Redirect;
   logic [31:0] RedirectPC;
   logic        InstValid;
   logic        InstReady;
   logic [31:0] InstCode;
   logic [31:0] InstPC;

   modport master (
      output IMemReq, IMemAddr, InstValid, InstCode, InstPC,
      input  IMemAck, IMemRdata, Redirect, RedirectPC, InstReady
   );

   modport slave (
      input  IMemReq, IMemAddr, InstValid, InstCode, InstPC,
      output IMemAck, IMemRdata, Redirect, RedirectPC, InstReady
   );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: owns the PC, fetches words over req/ack, and buffers them in a 2-entry queue.
// Latency: a word acked on edge N is presented on InstCode/InstPC from N+1 if the queue was empty.
// Backpressure: a new request is issued only when the queue has room; the head holds while !InstReady.
// Ports: Clk, ResetN (async active-low); bus.master carries the imem, redirect and decode signals.
module inst_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input logic              Clk,
   input logic              ResetN,
   inst_fetch_unit_if.master bus
);

   typedef enum logic [1:0] {IDLE, FETCH, DROP} state_t;

   state_t      state_q, state_d;
   logic        req_q;
   logic [31:0] pc_q, pc_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] code_q [2];
   logic [31:0] ipc_q  [2];
   logic        rd_ptr_q, wr_ptr_q;
   logic [1:0]  count_q, count_d, count_after;
   logic        ack, push, pop, room;
   logic [31:0] target;
   logic        unused_low_bits;

   // Low target bits are architecturally ignored.
   assign target          = {bus.RedirectPC[31:2], 2'b00};
   assign unused_low_bits = ^bus.RedirectPC[1:0];

   assign ack  = req_q && bus.IMemAck;
   // A redirect kills both the returning word and the decode-side pop.
   assign push = (state_q == FETCH) && ack && !bus.Redirect;
   assign pop  = (count_q != 2'd0) && bus.InstReady && !bus.Redirect;

   assign count_after = count_q + {1'b0, push} - {1'b0, pop};
   assign room        = (count_after < 2'd2);
   assign count_d     = bus.Redirect ? 2'd0 : count_after;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      case (state_q)
         IDLE: begin
            if (bus.Redirect) begin
               pc_d    = target;
               state_d = FETCH;
            end else if (room) begin
               state_d = FETCH;
            end
         end
         FETCH: begin
            if (bus.Redirect) begin
               pc_d    = target;
               // Without the ack the memory is still busy with the old address.
               state_d = ack ? FETCH : DROP;
            end else if (ack) begin
               pc_d    = addr_q + 32'd4;
               state_d = room ? FETCH : IDLE;
            end
         end
         DROP: begin
            if (bus.Redirect) pc_d = target;
            if (ack)          state_d = FETCH;
         end
         default: state_d = IDLE;
      endcase
      // The address may only move once the outstanding request has completed.
      addr_d = (state_d == DROP) ? addr_q : pc_d;
   end

   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         state_q  <= IDLE;
         req_q    <= 1'b0;
         pc_q     <= RESET_PC;
         addr_q   <= RESET_PC;
         count_q  <= 2'd0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            code_q[i] <= NOP_INST;
            ipc_q[i]  <= 32'h0;
         end
      end else begin
         state_q <= state_d;
         req_q   <= (state_d != IDLE);
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         count_q <= count_d;
         if (bus.Redirect) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
         end else begin
            if (push) begin
               code_q[wr_ptr_q] <= bus.IMemRdata;
               ipc_q[wr_ptr_q]  <= addr_q;
               wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
         end
      end
   end

   assign bus.IMemReq   = req_q;
   assign bus.IMemAddr  = addr_q;
   assign bus.InstValid = (count_q != 2'd0);
   // An empty queue shows a NOP so decode never sees a flushed word.
   assign bus.InstCode  = bus.InstValid ? code_q[rd_ptr_q] : NOP_INST;
   assign bus.InstPC    = bus.InstValid ? ipc_q[rd_ptr_q]  : 32'h0;

endmodule
